nco_bank: RTL

Parametrised bank of NUM_CH phase-accumulator oscillators sharing one time-multiplexed datapath, clocked from the 48 MHz system clock with an internal sample-rate divider. Each channel has its own frequency word and waveform select (saw, pulse, triangle, mute). Outputs are presented as a per-sample stream of (channel, value) words that feed the PDM/mixer stage. An optional falling-edge hard sync can reset a masked subset of channels.

---
 rtl/nco_bank.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/nco_bank.sv
// nco_bank: NUM_CH phase-accumulator oscillators sharing one time-multiplexed datapath.
// Define NCO_BANK_SYNC_EN to build the falling-edge hard-sync path.
module nco_bank #(
  parameter int NUM_CH = 4,
  parameter int PHS_W  = 32,
  parameter int OUT_W  = 16,
  parameter int DIV    = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frq_we,
  input  logic [CH_W-1:0]     frq_sel,
  input  logic [PHS_W-1:0]    frq_wdata,
  input  logic [2*NUM_CH-1:0] wave_sel,
  input  logic [11:0]         pw,
  input  logic                sync,
  input  logic [NUM_CH-1:0]   sync_mask,
  output logic [OUT_W-1:0]    out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_valid,
  output logic [NUM_CH-1:0]   rate
);

  localparam int FC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  if ((DIV < NUM_CH + 2) || (OUT_W > PHS_W - 1)) begin : g_param_chk
    $error("nco_bank: requires DIV >= NUM_CH+2 and OUT_W <= PHS_W-1");
  end

  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [0:0]       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d, slot_ch;
  logic             slot_en, frame_start, sync_clr, sel_ok;
  logic [PHS_W-1:0] phs_q [NUM_CH];
  logic [PHS_W-1:0] frq_q [NUM_CH];
  logic [PHS_W-1:0] phs_d;
  logic [1:0]       ws;
  logic [OUT_W-1:0] tri_x, tri_u, wave_d;
  logic [OUT_W-1:0] out_data_q;
  logic [CH_W-1:0]  out_ch_q;
  logic             out_valid_q;
  logic [NUM_CH-1:0] rate_q;

  assign frame_start = (fcnt_q == '0);
  assign fcnt_d      = (fcnt_q == FC_W'(DIV - 1)) ? '0 : fcnt_q + 1'b1;

  if ((1 << CH_W) == NUM_CH) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (frq_sel < CH_W'(NUM_CH));
  end

  // Channel 0's slot is the frame-start cycle itself, served from IDLE; RUN covers channels 1..NUM_CH-1.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    slot_en = 1'b0;
    slot_ch = '0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          slot_en = 1'b1;
          if (NUM_CH > 1) begin
            state_d = S_RUN;
            ch_d    = CH_W'(1);
          end
        end
      end
      default: begin
        slot_en = 1'b1;
        slot_ch = ch_q;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = S_IDLE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
    endcase
  end

`ifdef NCO_BANK_SYNC_EN
  logic sync_meta_q, sync_s_q, sync_prev_q, sync_pend_q, sync_act_q;
  logic sync_fall, sync_act_eff;

  assign sync_fall    = sync_prev_q & ~sync_s_q;
  // The frame-start slot must already see the freshly copied pending flag.
  assign sync_act_eff = frame_start ? sync_pend_q : sync_act_q;
  assign sync_clr     = sync_act_eff & sync_mask[slot_ch];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_s_q    <= 1'b0;
      sync_prev_q <= 1'b0;
      sync_pend_q <= 1'b0;
      sync_act_q  <= 1'b0;
    end else begin
      sync_meta_q <= sync;
      sync_s_q    <= sync_meta_q;
      sync_prev_q <= sync_s_q;
      if (frame_start) begin
        sync_act_q  <= sync_pend_q;
        sync_pend_q <= sync_fall;
      end else if (sync_fall) begin
        sync_pend_q <= 1'b1;
      end
    end
  end
`else
  logic unused_sync;
  assign unused_sync = ^{sync, sync_mask};
  assign sync_clr    = 1'b0;
`endif

  always_comb begin
    phs_d  = sync_clr ? '0 : phs_q[slot_ch] + frq_q[slot_ch];
    tri_x  = phs_d[PHS_W-2 -: OUT_W];
    tri_u  = phs_d[PHS_W-1] ? ~tri_x : tri_x;
    ws     = wave_sel[2*slot_ch +: 2];
    wave_d = '0;
    case (ws)
      2'b00:   wave_d = phs_d[PHS_W-1 -: OUT_W];
      2'b01:   wave_d = (phs_d[PHS_W-1 -: 12] < pw) ? POS_MAX : NEG_MAX;
      2'b10:   wave_d = {~tri_u[OUT_W-1], tri_u[OUT_W-2:0]};
      default: wave_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q      <= '0;
      state_q     <= S_IDLE;
      ch_q        <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rate_q      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        phs_q[i] <= '0;
        frq_q[i] <= '0;
      end
    end else begin
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      out_valid_q <= slot_en;
      if (slot_en) begin
        phs_q[slot_ch]  <= phs_d;
        rate_q[slot_ch] <= phs_d[PHS_W-1];
        out_data_q      <= wave_d;
        out_ch_q        <= slot_ch;
      end
      if (frq_we && sel_ok) begin
        frq_q[frq_sel] <= frq_wdata;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign rate      = rate_q;

endmodule
